// File: rtl/icache_fetch_pkg.sv
// -----------------------------------------------------------------------------
// icache_fetch_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - address/data width constants (ADDR_TYPE_WIDTH, DATA_TYPE_WIDTH)
//   - TRUE/FALSE single-bit constants
//   - controller state encoding (IC_IDLE, IC_MISS, IC_DROP)
// Optional feature macro used by the top level: ICACHE_PERF_EN.
// -----------------------------------------------------------------------------
package icache_fetch_pkg;

  localparam int ADDR_TYPE_WIDTH = 32;
  localparam int DATA_TYPE_WIDTH = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [DATA_TYPE_WIDTH-1:0] data_t;

  // IC_DROP: a flushed miss whose fill must still be absorbed, because the
  // memory controller cannot abort a request once issued.
  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_MISS = 2'd1,
    IC_DROP = 2'd2
  } ic_state_t;

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Valid/tag/data storage for a direct-mapped cache with one-word lines.
// Combinational read on rd_idx, one synchronous write port. Only the valid
// bits are reset (asynchronously); tag and data contents are don't-care until
// their valid bit is set.
// Ports:
//   clk, rst_n         clock, async active-low reset (clears valid bits)
//   rd_idx             read index
//   rd_valid/tag/data  combinational read result
//   wr_en              write strobe (sets valid[wr_idx])
//   wr_idx/tag/data    write index, tag and data
// -----------------------------------------------------------------------------
module icache_array
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = ADDR_TYPE_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [INDEX_BITS-1:0]            rd_idx,
  output logic                             rd_valid,
  output logic [ADDR_WIDTH-INDEX_BITS-3:0] rd_tag,
  output data_t                            rd_data,
  input  logic                             wr_en,
  input  logic [INDEX_BITS-1:0]            wr_idx,
  input  logic [ADDR_WIDTH-INDEX_BITS-3:0] wr_tag,
  input  data_t                            wr_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  data_t            data_r [LINES];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data storage, written together on a fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];
  assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/icache_fetch.sv
// -----------------------------------------------------------------------------
// icache_fetch
// Direct-mapped instruction cache (2^INDEX_BITS one-word lines) sitting
// between the fetch stage and the memory controller fetch port.
// Hits return the instruction one cycle after the request; misses issue a
// level request to the memory controller and return the fill word one cycle
// after it arrives. A flush cancels any pending response; a flushed miss still
// fills its line. rdy_in=0 freezes every register.
// Ports:
//   clk_in, rst_n_in     clock, async active-low reset
//   rdy_in               global pause
//   if_to_ic_valid/pc    fetch request (sampled only while ic_busy=0)
//   if_flush             pipeline flush
//   ic_busy              high whenever not IDLE
//   ic_to_if_ready/inst  one-cycle instruction return
//   ic_to_mc_PC/ready    miss request to the memory controller
//   mc_to_ic_result/ready  fill word and its one-cycle strobe
//   ic_hit_cnt/miss_cnt  accepted hit/miss counters (only with ICACHE_PERF_EN)
// Optional feature macro: ICACHE_PERF_EN.
// -----------------------------------------------------------------------------
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = ADDR_TYPE_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  if_to_ic_valid,
  input  logic [ADDR_WIDTH-1:0] if_to_ic_pc,
  input  logic                  if_flush,
  output logic                  ic_busy,
  output logic                  ic_to_if_ready,
  output data_t                 ic_to_if_inst,
  output logic [ADDR_WIDTH-1:0] ic_to_mc_PC,
  output logic                  ic_to_mc_ready,
`ifdef ICACHE_PERF_EN
  output logic [31:0]           ic_hit_cnt,
  output logic [31:0]           ic_miss_cnt,
`endif
  input  data_t                 mc_to_ic_result,
  input  logic                  mc_to_ic_ready
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  ic_state_t             state_r, state_s;
  logic                  busy_r;
  logic                  if_ready_r, if_ready_s;
  data_t                 inst_r, inst_s;
  logic                  mc_ready_r, mc_ready_s;
  logic [ADDR_WIDTH-1:0] mc_pc_r, mc_pc_s;
  logic                  wr_en_s;
  logic                  hit_inc_s, miss_inc_s;
  logic                  rd_valid_s;
  logic [TAG_W-1:0]      rd_tag_s;
  data_t                 rd_data_s;
  logic                  hit_s;
  logic                  unused_pc_s;

  // Byte offset of the PC is irrelevant for word fetches.
  assign unused_pc_s = ^if_to_ic_pc[1:0];

  // Lookup uses the incoming PC; fills use the latched miss address, which
  // stays stable for the whole MISS/DROP period.
  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .rd_idx   (if_to_ic_pc[INDEX_BITS+1:2]),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .rd_data  (rd_data_s),
    .wr_en    (wr_en_s),
    .wr_idx   (mc_pc_r[INDEX_BITS+1:2]),
    .wr_tag   (mc_pc_r[ADDR_WIDTH-1:INDEX_BITS+2]),
    .wr_data  (mc_to_ic_result)
  );

  assign hit_s = rd_valid_s && (rd_tag_s == if_to_ic_pc[ADDR_WIDTH-1:INDEX_BITS+2]);

  // Next-state and next-output logic; everything holds while paused.
  always_comb begin
    state_s    = state_r;
    if_ready_s = if_ready_r;
    inst_s     = inst_r;
    mc_ready_s = mc_ready_r;
    mc_pc_s    = mc_pc_r;
    wr_en_s    = FALSE;
    hit_inc_s  = FALSE;
    miss_inc_s = FALSE;
    if (rdy_in) begin
      if_ready_s = FALSE;
      case (state_r)
        IC_IDLE: begin
          if (if_flush) begin
            // Flush beats a simultaneous request.
            state_s = IC_IDLE;
          end else if (if_to_ic_valid && hit_s) begin
            if_ready_s = TRUE;
            inst_s     = rd_data_s;
            hit_inc_s  = TRUE;
          end else if (if_to_ic_valid) begin
            mc_pc_s    = {if_to_ic_pc[ADDR_WIDTH-1:2], 2'b00};
            mc_ready_s = TRUE;
            miss_inc_s = TRUE;
            state_s    = IC_MISS;
          end else begin
            state_s = IC_IDLE;
          end
        end
        IC_MISS: begin
          if (mc_to_ic_ready) begin
            wr_en_s    = TRUE;
            mc_ready_s = FALSE;
            state_s    = IC_IDLE;
            if (!if_flush) begin
              if_ready_s = TRUE;
              inst_s     = mc_to_ic_result;
            end else begin
              if_ready_s = FALSE;
            end
          end else if (if_flush) begin
            state_s = IC_DROP;
          end else begin
            state_s = IC_MISS;
          end
        end
        IC_DROP: begin
          if (mc_to_ic_ready) begin
            wr_en_s    = TRUE;
            mc_ready_s = FALSE;
            state_s    = IC_IDLE;
          end else begin
            state_s = IC_DROP;
          end
        end
        default: begin
          state_s    = IC_IDLE;
          mc_ready_s = FALSE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r    <= IC_IDLE;
      busy_r     <= FALSE;
      if_ready_r <= FALSE;
      inst_r     <= '0;
      mc_ready_r <= FALSE;
      mc_pc_r    <= '0;
    end else begin
      state_r    <= state_s;
      busy_r     <= (state_s != IC_IDLE);
      if_ready_r <= if_ready_s;
      inst_r     <= inst_s;
      mc_ready_r <= mc_ready_s;
      mc_pc_r    <= mc_pc_s;
    end
  end

  assign ic_busy        = busy_r;
  assign ic_to_if_ready = if_ready_r;
  assign ic_to_if_inst  = inst_r;
  assign ic_to_mc_ready = mc_ready_r;
  assign ic_to_mc_PC    = mc_pc_r;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_r, miss_cnt_r;

  // Accepted-request counters; increments are only raised while rdy_in=1.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      hit_cnt_r  <= hit_cnt_r + {31'd0, hit_inc_s};
      miss_cnt_r <= miss_cnt_r + {31'd0, miss_inc_s};
    end
  end

  assign ic_hit_cnt  = hit_cnt_r;
  assign ic_miss_cnt = miss_cnt_r;
`else
  logic unused_perf_s;
  assign unused_perf_s = hit_inc_s ^ miss_inc_s;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// -----------------------------------------------------------------------------
// tb_icache_fetch
// Self-checking bench for icache_fetch (default build, ICACHE_PERF_EN off).
// A table of directed fetches, hand-written pause/reset sequences, then random
// fetches checked against a model that records which aligned address each
// line currently holds. The memory controller is emulated inline with a
// chosen latency; memory contents come from mem_word().
// -----------------------------------------------------------------------------
module tb_icache_fetch;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        valid;
  logic [31:0] pc;
  logic        flush;
  logic        busy;
  logic        if_ready;
  logic [31:0] inst;
  logic [31:0] mc_pc;
  logic        mc_ready;
  logic [31:0] mc_res;
  logic        mc_rdy;

  int total = 0;
  int bad   = 0;

  // Model: for each of the 64 lines, whether it holds a word and which address.
  logic        ref_v [64];
  logic [31:0] ref_a [64];

  typedef struct {
    logic [31:0] pc;
    int          flush_at;  // -1 none, 0 with the request, n>=1 from miss cycle n on
    int          lat;       // miss cycle on which the fill pulse arrives
    logic        exp_miss;
    logic        exp_ready;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t tbl [12];

  icache_fetch dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .rdy_in          (rdy),
    .if_to_ic_valid  (valid),
    .if_to_ic_pc     (pc),
    .if_flush        (flush),
    .ic_busy         (busy),
    .ic_to_if_ready  (if_ready),
    .ic_to_if_inst   (inst),
    .ic_to_mc_PC     (mc_pc),
    .ic_to_mc_ready  (mc_ready),
    .mc_to_ic_result (mc_res),
    .mc_to_ic_ready  (mc_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) begin
      ref_v[i] = 1'b0;
      ref_a[i] = 32'd0;
    end
  endtask

  // One fetch transaction, with an inline memory-controller response.
  task automatic fetch(input logic [31:0] a, input int fa, input int lat,
                       input logic em, input logic er, input logic [31:0] ei);
    logic [31:0] al;
    int          idx;
    al  = {a[31:2], 2'b00};
    idx = int'(a[7:2]);
    @(negedge clk);
    chk("idle_ready_low", {31'd0, if_ready}, 32'd0);
    chk("idle_busy_low", {31'd0, busy}, 32'd0);
    valid = 1'b1;
    pc    = a;
    flush = (fa == 0);
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
    chk("req_mc_ready", {31'd0, mc_ready}, {31'd0, em});
    chk("req_busy", {31'd0, busy}, {31'd0, em});
    if (!em) begin
      chk("hit_ready", {31'd0, if_ready}, {31'd0, er});
      if (er) chk("hit_inst", inst, ei);
    end else begin
      chk("miss_pc", mc_pc, al);
      chk("miss_no_ready", {31'd0, if_ready}, 32'd0);
      for (int c = 1; c <= lat; c++) begin
        flush  = (fa >= 1) && (c >= fa);
        mc_rdy = (c == lat);
        mc_res = mem_word(al);
        @(negedge clk);
        flush  = 1'b0;
        mc_rdy = 1'b0;
        if (c < lat) begin
          chk("wait_mc_ready", {31'd0, mc_ready}, 32'd1);
          chk("wait_pc_stable", mc_pc, al);
          chk("wait_no_ready", {31'd0, if_ready}, 32'd0);
        end else begin
          chk("fill_mc_drop", {31'd0, mc_ready}, 32'd0);
          chk("fill_busy_low", {31'd0, busy}, 32'd0);
          chk("fill_ready", {31'd0, if_ready}, {31'd0, er});
          if (er) chk("fill_inst", inst, ei);
        end
      end
      ref_v[idx] = 1'b1;
      ref_a[idx] = al;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] al;
    int          lat;
    int          fa;
    int          idx;
    logic        hit;

    tbl[0]  = '{32'h0000_0100, -1, 4, 1'b1, 1'b1, 32'h0000_0013};
    tbl[1]  = '{32'h0000_0100, -1, 0, 1'b0, 1'b1, 32'h0000_0013};
    tbl[2]  = '{32'h0000_0200, -1, 3, 1'b1, 1'b1, mem_word(32'h0000_0200)};
    tbl[3]  = '{32'h0000_0100, -1, 2, 1'b1, 1'b1, 32'h0000_0013};
    tbl[4]  = '{32'h0000_0300,  2, 4, 1'b1, 1'b0, 32'd0};
    tbl[5]  = '{32'h0000_0300, -1, 0, 1'b0, 1'b1, mem_word(32'h0000_0300)};
    tbl[6]  = '{32'h0000_0500,  3, 3, 1'b1, 1'b0, 32'd0};
    tbl[7]  = '{32'h0000_0500, -1, 0, 1'b0, 1'b1, mem_word(32'h0000_0500)};
    tbl[8]  = '{32'h0000_0500,  0, 0, 1'b0, 1'b0, 32'd0};
    tbl[9]  = '{32'h0000_0102, -1, 1, 1'b1, 1'b1, 32'h0000_0013};
    tbl[10] = '{32'hFFFF_FFFC, -1, 2, 1'b1, 1'b1, mem_word(32'hFFFF_FFFC)};
    tbl[11] = '{32'hFFFF_FFFF, -1, 0, 1'b0, 1'b1, mem_word(32'hFFFF_FFFC)};

    clear_model();
    rst_n  = 1'b0;
    rdy    = 1'b1;
    valid  = 1'b0;
    pc     = 32'd0;
    flush  = 1'b0;
    mc_res = 32'd0;
    mc_rdy = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_mc_ready", {31'd0, mc_ready}, 32'd0);
    chk("rst_mc_pc", mc_pc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      fetch(tbl[i].pc, tbl[i].flush_at, tbl[i].lat,
            tbl[i].exp_miss, tbl[i].exp_ready, tbl[i].exp_inst);
    end

    // Pause during MISS: a fill pulse while rdy=0 must be ignored.
    @(negedge clk);
    valid = 1'b1;
    pc    = 32'h0000_0600;
    @(negedge clk);
    valid = 1'b0;
    chk("pause_miss_issue", {31'd0, mc_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      rdy    = 1'b0;
      mc_rdy = (k == 1);
      mc_res = mem_word(32'h0000_0600);
      @(negedge clk);
      mc_rdy = 1'b0;
      chk("pause_mc_held", {31'd0, mc_ready}, 32'd1);
      chk("pause_busy", {31'd0, busy}, 32'd1);
      chk("pause_no_ready", {31'd0, if_ready}, 32'd0);
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("unpause_still_miss", {31'd0, mc_ready}, 32'd1);
    chk("unpause_pc", mc_pc, 32'h0000_0600);
    mc_rdy = 1'b1;
    mc_res = mem_word(32'h0000_0600);
    @(negedge clk);
    mc_rdy = 1'b0;
    chk("unpause_fill_ready", {31'd0, if_ready}, 32'd1);
    chk("unpause_fill_inst", inst, mem_word(32'h0000_0600));
    chk("unpause_mc_drop", {31'd0, mc_ready}, 32'd0);
    ref_v[0] = 1'b1;
    ref_a[0] = 32'h0000_0600;
    fetch(32'h0000_0600, -1, 0, 1'b0, 1'b1, mem_word(32'h0000_0600));

    // Asynchronous reset in the middle of a miss.
    @(negedge clk);
    valid = 1'b1;
    pc    = 32'h0000_0704;
    @(negedge clk);
    valid = 1'b0;
    chk("rmid_miss_issue", {31'd0, mc_ready}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_mc_ready", {31'd0, mc_ready}, 32'd0);
    chk("rmid_mc_pc", mc_pc, 32'd0);
    chk("rmid_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rmid_inst", inst, 32'd0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    // Valid bits were cleared, so a previously cached line must miss.
    fetch(32'h0000_0600, -1, 2, 1'b1, 1'b1, mem_word(32'h0000_0600));

    // Random fetches against the model.
    for (int n = 0; n < 80; n++) begin
      a   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
      al  = {a[31:2], 2'b00};
      idx = int'(a[7:2]);
      lat = $urandom_range(1, 5);
      fa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat)) : -1;
      hit = ref_v[idx] && (ref_a[idx] == al);
      if (fa == 0) begin
        fetch(a, fa, lat, 1'b0, 1'b0, 32'd0);
      end else if (hit) begin
        fetch(a, fa, lat, 1'b0, 1'b1, mem_word(al));
      end else begin
        fetch(a, fa, lat, 1'b1, (fa < 1), mem_word(al));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
